etapa_memoria: RTL

- MEM stage of the MIPS pipeline: issues loads and stores to the external data-memory bus with a req/ack handshake.
- Aligns byte, halfword and word loads and stores.
- Holds the MEM/WB pipeline register that feeds the writeback result mux.
- Stalls upstream stages while a memory access is outstanding, and aborts an access on timeout or misalignment.

---
 rtl/etapa_memoria_pkg.sv | 14 +
 rtl/etapa_memoria_alineador_carga.sv | 33 +++
 rtl/etapa_memoria.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/etapa_memoria_pkg.sv
// Shared encodings for the MEM stage: access sizes and FSM states.
package etapa_memoria_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/etapa_memoria_alineador_carga.sv
// Load aligner: selects the addressed byte/halfword lane of the read word
// and sign- or zero-extends it to 32 bits. Words pass through unchanged.
module alineador_carga
  import etapa_memoria_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select plus extension
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = i_rdata;
    case (i_size)
      SIZE_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      SIZE_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default:   o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/etapa_memoria.sv
// MIPS MEM stage: issues aligned loads/stores on a req/ack data bus,
// stalls upstream while an access is outstanding, aborts on misalignment
// or timeout, and holds the MEM/WB pipeline register.
module etapa_memoria
  import etapa_memoria_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_mem,
  output logic        addr_error,
  output logic        bus_error,
  output logic        wb_valid,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic [4:0]  wb_write_reg
);

  state_t          r_state, w_next;
  logic [TO_W-1:0] r_cnt;
  logic            w_memop, w_misalign, w_go, w_stall, w_timeout;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata, w_load;

  // Instruction captured at request time, consumed when the access ends
  logic [31:0] r_op_alu;
  logic [1:0]  r_op_size;
  logic        r_op_uns, r_op_load, r_op_m2r, r_op_rw;
  logic [4:0]  r_op_wr;

  assign w_memop    = valid_in & (mem_read | mem_write);
  assign w_misalign = (mem_size == SIZE_RSVD)
                    | ((mem_size == SIZE_HALF) & alu_result[0])
                    | ((mem_size == SIZE_WORD) & (|alu_result[1:0]));
  assign w_timeout  = (r_cnt == TO_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and stall; stall is released in the ack or timeout cycle
  // so upstream advances on the same edge that loads MEM/WB.
  always_comb begin
    w_next  = r_state;
    w_go    = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_memop && !w_misalign) begin
          w_go    = 1'b1;
          w_stall = 1'b1;
          w_next  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ack || w_timeout) w_next  = ST_IDLE;
        else                      w_stall = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Gated by reset so the combinational stall is also 0 while in reset
  assign stall_mem = w_stall & rst_n;

  // Store lane replication and byte enables
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = write_data;
    case (mem_size)
      SIZE_BYTE: begin
        w_be    = 4'b0001 << alu_result[1:0];
        w_wdata = {4{write_data[7:0]}};
      end
      SIZE_HALF: begin
        w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  alineador_carga u_alineador (
    .i_rdata    (mem_rdata),
    .i_addr_lo  (r_op_alu[1:0]),
    .i_size     (r_op_size),
    .i_unsigned (r_op_uns),
    .o_data     (w_load)
  );

  // Bus request, timeout counter, error pulses and MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
      addr_error    <= 1'b0;
      bus_error     <= 1'b0;
      wb_valid      <= 1'b0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_write_reg  <= '0;
      r_op_alu      <= '0;
      r_op_size     <= '0;
      r_op_uns      <= 1'b0;
      r_op_load     <= 1'b0;
      r_op_m2r      <= 1'b0;
      r_op_rw       <= 1'b0;
      r_op_wr       <= '0;
    end else begin
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          wb_alu_result <= alu_result;
          wb_read_data  <= '0;
          wb_mem_to_reg <= mem_to_reg;
          wb_write_reg  <= write_reg;
          if (w_go) begin
            r_cnt        <= '0;
            mem_req      <= 1'b1;
            mem_we       <= mem_write;
            mem_addr     <= {alu_result[31:2], 2'b00};
            mem_be       <= w_be;
            mem_wdata    <= w_wdata;
            r_op_alu     <= alu_result;
            r_op_size    <= mem_size;
            r_op_uns     <= mem_unsigned;
            r_op_load    <= mem_read;
            r_op_m2r     <= mem_to_reg;
            r_op_rw      <= reg_write;
            r_op_wr      <= write_reg;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end else if (w_memop) begin
            addr_error   <= 1'b1;
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
          end else begin
            wb_valid     <= valid_in;
            wb_reg_write <= reg_write;
          end
        end
        ST_ACCESS: begin
          if (mem_ack || w_timeout) begin
            mem_req       <= 1'b0;
            wb_valid      <= 1'b1;
            wb_alu_result <= r_op_alu;
            wb_mem_to_reg <= r_op_m2r;
            wb_write_reg  <= r_op_wr;
            if (mem_ack) begin
              wb_read_data <= r_op_load ? w_load : '0;
              wb_reg_write <= r_op_rw;
            end else begin
              bus_error    <= 1'b1;
              wb_read_data <= '0;
              wb_reg_write <= 1'b0;
            end
          end else begin
            r_cnt    <= r_cnt + 1'b1;
            wb_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
